// File: rtl/prim_count_bank_pkg.sv
// Shared types and arithmetic helper for the hardened cross-counter bank.
package prim_count_bank_pkg;

    typedef enum logic [2:0] {
        CmdHold,
        CmdClr,
        CmdSet,
        CmdIncr,
        CmdDecr
    } cnt_cmd_e;

    localparam int MaxWidth = 32;

    // Extended add/subtract: for a Width-bit operand pair, bit Width of the
    // result is the carry (up) or borrow (down).
    function automatic logic [MaxWidth:0] ext_step(input logic [MaxWidth-1:0] val,
                                                   input logic [MaxWidth-1:0] step,
                                                   input logic                up);
        if (up) begin
            return {1'b0, val} + {1'b0, step};
        end
        return {1'b0, val} - {1'b0, step};
    endfunction

endpackage

// File: rtl/prim_count_bank_chan.sv
// One hardened channel: primary up-counter mirrored by a secondary down-counter.
// Optional sticky error latch enabled by PRIM_COUNT_BANK_STICKY_ERR_EN.
module prim_count_bank_chan
    import prim_count_bank_pkg::*;
#(
    parameter int              Width      = 8,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter bit              Wrap       = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             set,
    input  logic [Width-1:0] set_cnt,
    input  logic             incr_en,
    input  logic             decr_en,
    input  logic [Width-1:0] step,
    input  logic [Width-1:0] thresh,
    output logic [Width-1:0] cnt,
    output logic [Width-1:0] cnt_next,
    output logic             thresh_hit,
    output logic             ovf,
    output logic             unf,
    output logic             err
);

    localparam logic [Width-1:0] AllOnes = '1;

    cnt_cmd_e         cmd;
    logic [Width-1:0] pri_q, sec_q, pri_d, sec_d;
    logic [Width:0]   pri_ext;
    logic [Width-1:0] sec_ext;
    logic             up, carry, en, evt_ovf, evt_unf, err_live, frozen;
    logic             ovf_p1, unf_p1;

`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
    logic err_q;
    assign frozen = err_q;
`else
    assign frozen = 1'b0;
`endif

    always_comb begin
        cmd = CmdHold;
        if (frozen)                 cmd = CmdHold;
        else if (clr)               cmd = CmdClr;
        else if (set)               cmd = CmdSet;
        else if (incr_en && !decr_en) cmd = CmdIncr;
        else if (decr_en && !incr_en) cmd = CmdDecr;
    end

    assign up      = (cmd == CmdIncr);
    assign pri_ext = (Width+1)'(ext_step(MaxWidth'(pri_q), MaxWidth'(step), up));
    assign sec_ext = Width'(ext_step(MaxWidth'(sec_q), MaxWidth'(step), !up));
    assign carry   = pri_ext[Width];

    always_comb begin
        pri_d   = pri_q;
        sec_d   = sec_q;
        evt_ovf = 1'b0;
        evt_unf = 1'b0;
        en      = 1'b0;
        case (cmd)
            CmdClr: begin
                pri_d = ResetValue;
                sec_d = ~ResetValue;
                en    = 1'b1;
            end
            CmdSet: begin
                pri_d = set_cnt;
                sec_d = ~set_cnt;
                en    = 1'b1;
            end
            CmdIncr, CmdDecr: begin
                evt_ovf = up & carry;
                evt_unf = !up & carry;
                if (carry && !Wrap) begin
                    pri_d = up ? AllOnes : '0;
                    sec_d = up ? '0 : AllOnes;
                end else begin
                    pri_d = pri_ext[Width-1:0];
                    sec_d = sec_ext;
                end
                // Saturated channel sitting at its limit keeps its flops gated.
                en = (pri_d != pri_q) || (sec_d != sec_q);
            end
            default: ;
        endcase
    end

    // Two independent state registers; the invariant check relies on them staying separate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pri_q <= ResetValue;
        else if (en) pri_q <= pri_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sec_q <= ~ResetValue;
        else if (en) sec_q <= sec_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p1 <= 1'b0;
            unf_p1 <= 1'b0;
        end else begin
            ovf_p1 <= evt_ovf;
            unf_p1 <= evt_unf;
        end
    end

    assign err_live = ({1'b0, pri_q} + {1'b0, sec_q}) != {1'b0, AllOnes};

`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | err_live;
    end
    assign err = err_q | err_live;
`else
    assign err = err_live;
`endif

    assign cnt        = pri_q;
    assign cnt_next   = pri_d;
    assign thresh_hit = (pri_q >= thresh);
    assign ovf        = ovf_p1;
    assign unf        = unf_p1;

endmodule

// File: rtl/prim_count_bank.sv
// Bank of NumChan hardened cross counters with per-channel saturate/wrap mode.
// Build option PRIM_COUNT_BANK_STICKY_ERR_EN latches consistency errors and freezes the channel.
module prim_count_bank
    import prim_count_bank_pkg::*;
#(
    parameter int                 Width      = 8,
    parameter int                 NumChan    = 2,
    parameter logic [Width-1:0]   ResetValue = '0,
    parameter logic [NumChan-1:0] WrapMode   = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumChan-1:0]       clr_i,
    input  logic [NumChan-1:0]       set_i,
    input  logic [NumChan*Width-1:0] set_cnt_i,
    input  logic [NumChan-1:0]       incr_en_i,
    input  logic [NumChan-1:0]       decr_en_i,
    input  logic [NumChan*Width-1:0] step_i,
    input  logic [NumChan*Width-1:0] thresh_i,
    output logic [NumChan*Width-1:0] cnt_o,
    output logic [NumChan*Width-1:0] cnt_next_o,
    output logic [NumChan-1:0]       thresh_hit_o,
    output logic [NumChan-1:0]       ovf_o,
    output logic [NumChan-1:0]       unf_o,
    output logic [NumChan-1:0]       err_o,
    output logic                     err_any_o
);

    for (genvar k = 0; k < NumChan; k++) begin : g_chan
        prim_count_bank_chan #(
            .Width      (Width),
            .ResetValue (ResetValue),
            .Wrap       (WrapMode[k])
        ) u_chan (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .clr        (clr_i[k]),
            .set        (set_i[k]),
            .set_cnt    (set_cnt_i[k*Width +: Width]),
            .incr_en    (incr_en_i[k]),
            .decr_en    (decr_en_i[k]),
            .step       (step_i[k*Width +: Width]),
            .thresh     (thresh_i[k*Width +: Width]),
            .cnt        (cnt_o[k*Width +: Width]),
            .cnt_next   (cnt_next_o[k*Width +: Width]),
            .thresh_hit (thresh_hit_o[k]),
            .ovf        (ovf_o[k]),
            .unf        (unf_o[k]),
            .err        (err_o[k])
        );
    end

    assign err_any_o = |err_o;

endmodule

// File: tb/tb_prim_count_bank.sv
// Directed bench for prim_count_bank: Width=4, NumChan=2, ch0 saturating, ch1 wrapping.
module tb_prim_count_bank;
    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   clr_i, set_i, incr_en_i, decr_en_i;
    logic [N*W-1:0] set_cnt_i, step_i, thresh_i;
    logic [N*W-1:0] cnt_o, cnt_next_o;
    logic [N-1:0]   thresh_hit_o, ovf_o, unf_o, err_o;
    logic           err_any_o;

    int errors = 0;
    int checks = 0;

    prim_count_bank #(
        .Width      (W),
        .NumChan    (N),
        .ResetValue (4'd0),
        .WrapMode   (2'b10)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .set_i        (set_i),
        .set_cnt_i    (set_cnt_i),
        .incr_en_i    (incr_en_i),
        .decr_en_i    (decr_en_i),
        .step_i       (step_i),
        .thresh_i     (thresh_i),
        .cnt_o        (cnt_o),
        .cnt_next_o   (cnt_next_o),
        .thresh_hit_o (thresh_hit_o),
        .ovf_o        (ovf_o),
        .unf_o        (unf_o),
        .err_o        (err_o),
        .err_any_o    (err_any_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        clr_i     = '0;
        set_i     = '0;
        incr_en_i = '0;
        decr_en_i = '0;
    endtask

    task automatic load(input int k, input logic [W-1:0] v);
        idle();
        set_i[k]              = 1'b1;
        set_cnt_i[k*W +: W]   = v;
        tick();
        set_i[k]              = 1'b0;
    endtask

    task automatic count(input int k, input logic up, input logic [W-1:0] s);
        idle();
        step_i[k*W +: W] = s;
        if (up) incr_en_i[k] = 1'b1;
        else    decr_en_i[k] = 1'b1;
    endtask

    function automatic logic [W-1:0] cnt(input int k);
        return cnt_o[k*W +: W];
    endfunction

    initial begin
        rst_ni    = 1'b0;
        idle();
        set_cnt_i = '0;
        step_i    = '0;
        thresh_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", cnt_o, 8'h00);
        check("rst_sec0", dut.g_chan[0].u_chan.sec_q, 4'hf);
        check("rst_sec1", dut.g_chan[1].u_chan.sec_q, 4'hf);
        check("rst_ovf_unf", {ovf_o, unf_o}, 4'b0000);
        check("rst_err", {err_o, err_any_o}, 3'b000);
        check("rst_thresh0", thresh_hit_o, 2'b11);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // ch0 saturating overflow
        load(0, 4'd14);
        check("sat_set", cnt(0), 4'd14);
        count(0, 1'b1, 4'd3);
        #1;
        check("sat_next", cnt_next_o[3:0], 4'd15);
        tick();
        check("sat_cnt", cnt(0), 4'd15);
        check("sat_sec", dut.g_chan[0].u_chan.sec_q, 4'd0);
        check("sat_ovf", ovf_o, 2'b01);
        tick();
        check("sat_hold", cnt(0), 4'd15);
        check("sat_ovf2", ovf_o, 2'b01);
        idle();
        tick();
        check("sat_ovf_clr", ovf_o, 2'b00);

        // ch1 wrapping overflow then underflow
        load(1, 4'd14);
        count(1, 1'b1, 4'd3);
        tick();
        check("wrap_cnt", cnt(1), 4'd1);
        check("wrap_sec", dut.g_chan[1].u_chan.sec_q, 4'd14);
        check("wrap_ovf", ovf_o, 2'b10);
        count(1, 1'b0, 4'd2);
        tick();
        check("wrap_dec", cnt(1), 4'd15);
        check("wrap_dsec", dut.g_chan[1].u_chan.sec_q, 4'd0);
        check("wrap_unf", {ovf_o, unf_o}, 4'b0010);
        check("wrap_err", err_any_o, 1'b0);
        idle();
        tick();
        check("wrap_unf_clr", unf_o, 2'b00);

        // ch0 saturating underflow and zero step
        load(0, 4'd0);
        count(0, 1'b0, 4'd1);
        tick();
        check("satu_cnt", cnt(0), 4'd0);
        check("satu_unf", unf_o, 2'b01);
        count(0, 1'b1, 4'd0);
        tick();
        check("step0_cnt", cnt(0), 4'd0);
        check("step0_evt", {ovf_o, unf_o}, 4'b0000);

        // both enables, then clr vs set priority
        load(0, 4'd5);
        idle();
        incr_en_i[0] = 1'b1;
        decr_en_i[0] = 1'b1;
        step_i[3:0]  = 4'd1;
        tick();
        check("both_hold", cnt(0), 4'd5);
        check("both_evt", {ovf_o, unf_o}, 4'b0000);
        idle();
        clr_i[0]       = 1'b1;
        set_i[0]       = 1'b1;
        set_cnt_i[3:0] = 4'd9;
        tick();
        check("clr_wins", cnt(0), 4'd0);
        check("clr_evt", {ovf_o, unf_o}, 4'b0000);
        idle();

        // threshold compare
        thresh_i[3:0] = 4'd7;
        load(0, 4'd5);
        check("th_5", thresh_hit_o[0], 1'b0);
        count(0, 1'b1, 4'd1);
        tick();
        check("th_6", {cnt(0), thresh_hit_o[0]}, {4'd6, 1'b0});
        tick();
        check("th_7", {cnt(0), thresh_hit_o[0]}, {4'd7, 1'b1});
        tick();
        check("th_8", {cnt(0), thresh_hit_o[0]}, {4'd8, 1'b1});
        idle();

        // consistency error injection on ch0
        load(0, 4'd5);
        force dut.g_chan[0].u_chan.sec_q = 4'd3;
        #1;
        check("err_live", {err_o, err_any_o}, 3'b011);
        tick();
        force dut.g_chan[0].u_chan.sec_q = 4'd10;
        release dut.g_chan[0].u_chan.sec_q;
        #1;
        count(0, 1'b1, 4'd1);
`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
        check("err_sticky", {err_o, err_any_o}, 3'b011);
        tick();
        check("err_frozen", cnt(0), 4'd5);
        check("err_sticky2", err_o, 2'b01);
`else
        check("err_clear", {err_o, err_any_o}, 3'b000);
        tick();
        check("err_runs", cnt(0), 4'd6);
        check("err_clear2", err_o, 2'b00);
`endif

        // asynchronous reset mid-operation
        count(0, 1'b1, 4'd15);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_cnt", cnt_o, 8'h00);
        check("arst_state", {ovf_o, unf_o, err_o}, 6'b000000);
        idle();
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        check("arst_after", {cnt_o, err_any_o}, 9'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
